ahb_sram_slave: RTL and testbench

AHB-Lite slave responder for the processor's data-memory port: the memory end of the bus driven by the RF stage (HADDR/HWRITE/HTRANS/HWDATA). It accepts address phases, executes byte/half/word reads and writes into an internal SRAM array, and optionally inserts wait states. It returns two-cycle ERROR responses for illegal transfers. It sits on the data bus opposite the processor and drives the HRDATA/HREADY/HRESP the processor consumes.

---
 rtl/ahb_sram_slave_pkg.sv | 37 +++
 rtl/ahb_sram_slave_if.sv | 23 ++
 rtl/ahb_sram_array.sv | 29 ++
 rtl/ahb_sram_slave.sv | 150 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared AHB-Lite encodings, slave FSM states and lane helper
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    // Little-endian byte enables for a transfer of the given size at the given lane offset
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite data-memory port bundle
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_array.sv
// rtl/ahb_sram_array.sv - byte-writable 32-bit SRAM with asynchronous read
module ahb_sram_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    // Update only the enabled byte lanes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    ahb_sram_slave_if.slave  bus
);

    localparam logic [31:0] REGION_MASK = ~((32'h1 << (ADDR_WIDTH + 2)) - 32'h1);

    slave_state_t          state, state_next;
    logic [3:0]            count, count_next;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic [1:0]            cap_lane;
    logic                  cap_write;
    logic [2:0]            cap_size;
    logic [31:0]           rdata_hold;
    logic [31:0]           mem_rdata;
    logic [3:0]            cap_be;
    logic [31:0]           lane_mask;
    logic                  active_trans, can_accept, accept;
    logic                  aligned, in_region, size_ok, legal;
    logic                  read_phase, mem_we;

    assign active_trans = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
    // Only states that present HREADYOUT=1 may take a new address phase
    assign can_accept   = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept       = can_accept && bus.HSEL && bus.HREADY && active_trans;

    // Legality of the address phase currently on the bus
    always_comb begin
        aligned = 1'b1;
        case (bus.HSIZE)
            HSIZE_HALF: aligned = (bus.HADDR[0] == 1'b0);
            HSIZE_WORD: aligned = (bus.HADDR[1:0] == 2'b00);
            default:    aligned = 1'b1;
        endcase
    end

    assign in_region = (bus.HADDR & REGION_MASK) == (BASE_ADDR & REGION_MASK);
    assign size_ok   = (bus.HSIZE <= HSIZE_WORD);
    assign legal     = size_ok && aligned && in_region;

    // State and wait-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state and response outputs
    always_comb begin
        state_next    = state;
        count_next    = count;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = HRESP_OKAY;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state == ST_ERR2) begin
                    bus.HRESP = HRESP_ERROR;
                end
                if (accept) begin
                    if (!legal) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next = ST_WAIT;
                        count_next = 4'(WAIT_STATES);
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                bus.HREADYOUT = 1'b0;
                count_next    = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = ST_DATA;
                end
            end
            ST_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = HRESP_ERROR;
                state_next    = ST_ERR2;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address-phase capture on every accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_idx   <= '0;
            cap_lane  <= 2'b00;
            cap_write <= 1'b0;
            cap_size  <= 3'b000;
        end else if (accept) begin
            cap_idx   <= bus.HADDR[ADDR_WIDTH+1:2];
            cap_lane  <= bus.HADDR[1:0];
            cap_write <= bus.HWRITE;
            cap_size  <= bus.HSIZE;
        end
    end

    assign cap_be     = byte_enables(cap_size, cap_lane);
    assign read_phase = (state == ST_DATA) && !cap_write;
    assign mem_we     = (state == ST_DATA) && cap_write;

    // Expand byte enables into a mask that zeroes the unaddressed read lanes
    always_comb begin
        lane_mask = 32'h0;
        for (int b = 0; b < 4; b++) begin
            lane_mask[8*b +: 8] = {8{cap_be[b]}};
        end
    end

    // Keep the last read result on HRDATA between read data phases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_hold <= 32'h0;
        end else if (read_phase) begin
            rdata_hold <= mem_rdata & lane_mask;
        end
    end

    assign bus.HRDATA = read_phase ? (mem_rdata & lane_mask) : rdata_hold;

    ahb_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (cap_be),
        .waddr (cap_idx),
        .wdata (bus.HWDATA),
        .raddr (cap_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tgt;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    ahb_sram_slave_if bus0();
    ahb_sram_slave_if bus3();

    assign rdy   = tgt ? bus3.HREADYOUT : bus0.HREADYOUT;
    assign resp  = tgt ? bus3.HRESP     : bus0.HRESP;
    assign rdata = tgt ? bus3.HRDATA    : bus0.HRDATA;

    assign bus0.HSEL   = hsel & ~tgt;
    assign bus0.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = rdy;

    assign bus3.HSEL   = hsel & tgt;
    assign bus3.HADDR  = haddr;
    assign bus3.HTRANS = htrans;
    assign bus3.HWRITE = hwrite;
    assign bus3.HSIZE  = hsize;
    assign bus3.HWDATA = hwdata;
    assign bus3.HREADY = rdy;

    ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr(input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    task automatic count_waits(output int cnt);
        cnt = 0;
        while (rdy !== 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        tgt = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; haddr = 32'h0;
        hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 32'h0;

        #12;
        check("rst_ready0", {31'h0, bus0.HREADYOUT}, 32'h1);
        check("rst_resp0",  {31'h0, bus0.HRESP}, 32'h0);
        check("rst_rdata0", bus0.HRDATA, 32'h0);
        check("rst_ready3", {31'h0, bus3.HREADYOUT}, 32'h1);
        tick();
        rst = 1'b0;
        tick();

        // word write then read, zero wait, pipelined
        addr(32'h10, 1'b1, HSIZE_WORD); tick();
        check("wr_ready", {31'h0, rdy}, 32'h1);
        hwdata = 32'hDEAD_BEEF; addr(32'h10, 1'b0, HSIZE_WORD); tick();
        check("rd_ready", {31'h0, rdy}, 32'h1);
        check("rd_word", rdata, 32'hDEAD_BEEF);
        idle(); tick();
        check("rd_hold", rdata, 32'hDEAD_BEEF);

        // byte write into a preloaded word, then sub-word reads
        addr(32'h20, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'h1122_3344; addr(32'h22, 1'b1, HSIZE_BYTE); tick();
        hwdata = 32'h00AA_0000; addr(32'h20, 1'b0, HSIZE_WORD); tick();
        check("byte_wr_word", rdata, 32'h11AA_3344);
        addr(32'h22, 1'b0, HSIZE_HALF); tick();
        check("half_rd", rdata, 32'h11AA_0000);
        addr(32'h21, 1'b0, HSIZE_BYTE); tick();
        check("byte_rd", rdata, 32'h0000_3300);
        idle(); tick();

        // read-after-write back to back, then BUSY/IDLE/unselected
        addr(32'h40, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'h5; addr(32'h40, 1'b0, HSIZE_WORD); tick();
        check("raw", rdata, 32'h5);
        hsel = 1'b1; htrans = HTRANS_BUSY; tick();
        check("busy_ready", {31'h0, rdy}, 32'h1);
        check("busy_resp", {31'h0, resp}, 32'h0);
        check("busy_hold", rdata, 32'h5);
        htrans = HTRANS_IDLE; tick();
        check("idle_ready", {31'h0, rdy}, 32'h1);
        hsel = 1'b0; htrans = HTRANS_NONSEQ; tick();
        check("nosel_ready", {31'h0, rdy}, 32'h1);
        check("nosel_resp", {31'h0, resp}, 32'h0);
        idle(); tick();

        // error responses; none may touch memory
        hwdata = 32'hFFFF_FFFF;
        addr(32'h13, 1'b1, HSIZE_WORD); tick();
        check("mis_err1", {30'h0, rdy, resp}, 32'h1);
        idle(); tick();
        check("mis_err2", {30'h0, rdy, resp}, 32'h3);
        addr(32'h10, 1'b1, 3'b011); tick();
        check("size_err1", {30'h0, rdy, resp}, 32'h1);
        idle(); tick();
        check("size_err2", {30'h0, rdy, resp}, 32'h3);
        addr(32'h1010, 1'b1, HSIZE_WORD); tick();
        check("base_err1", {30'h0, rdy, resp}, 32'h1);
        idle(); tick();
        check("base_err2", {30'h0, rdy, resp}, 32'h3);
        addr(32'h10, 1'b0, HSIZE_WORD); tick();
        check("err_nowrite", rdata, 32'hDEAD_BEEF);
        check("err_okay", {30'h0, rdy, resp}, 32'h2);
        idle(); tick();

        // three wait states
        tgt = 1'b1;
        addr(32'hC, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'h1234_5678; addr(32'h8, 1'b1, HSIZE_WORD);
        count_waits(n);
        check("ws_wr_c", n, 3);
        tick();
        hwdata = 32'hCAFE_F00D; addr(32'h8, 1'b0, HSIZE_WORD);
        count_waits(n);
        check("ws_wr_8", n, 3);
        tick();
        addr(32'hC, 1'b0, HSIZE_WORD);
        count_waits(n);
        check("ws_rd_8_waits", n, 3);
        check("ws_rd_8", rdata, 32'hCAFE_F00D);
        tick();
        idle();
        check("ws_hold", rdata, 32'hCAFE_F00D);
        count_waits(n);
        check("ws_rd_c_waits", n, 3);
        check("ws_rd_c", rdata, 32'h1234_5678);
        tick();

        // reset in the middle of a write's wait states
        hwdata = 32'hBAD0_BAD0; addr(32'h8, 1'b1, HSIZE_WORD); tick();
        check("pre_rst_wait", {31'h0, rdy}, 32'h0);
        idle();
        rst = 1'b1;
        #1;
        check("rst_wait_out", {rdy, resp, 30'h0}, 32'h8000_0000);
        check("rst_wait_rdata", rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        addr(32'h8, 1'b0, HSIZE_WORD); tick();
        idle();
        count_waits(n);
        check("rst_abort", rdata, 32'hCAFE_F00D);
        tick();
        tgt = 1'b0;
        addr(32'h10, 1'b0, HSIZE_WORD); tick();
        check("rst_keep_mem", rdata, 32'hDEAD_BEEF);
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
